// File: rtl/axi_lite_regfile_slave.sv
// AXI4-Lite slave in front of a flat register file with write pulses and SLVERR decode.
// Define AXI_REGFILE_WSTRB_EN to honour byte strobes; otherwise every commit writes the full word.
module axi_lite_regfile_slave #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  output logic [1:0]                     s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  output logic [DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [1:0]                     s_axi_rresp,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  localparam int ADDR_LSB = $clog2(DATA_WIDTH/8);
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                           r_awready, r_wready, r_arready;
  logic                           r_aw_held, r_w_held;
  logic [IDX_W-1:0]               r_aw_idx;
  logic [DATA_WIDTH-1:0]          r_w_data;
  logic                           r_bvalid;
  logic [1:0]                     r_bresp;
  logic                           r_rvalid;
  logic [1:0]                     r_rresp;
  logic [DATA_WIDTH-1:0]          r_rdata;
  logic [NUM_REGS-1:0]            r_wr_pulse;

  logic                           w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic [IDX_W-1:0]               w_widx, w_ridx;
  logic                           w_w_in_range, w_r_in_range;
  logic [DATA_WIDTH-1:0]          w_wdata, w_rd_word;
  logic [NUM_REGS-1:0]            w_we;
  logic [NUM_REGS*DATA_WIDTH-1:0] w_regs_flat;
  logic                           w_unused_bits;

  assign w_aw_hs  = s_axi_awvalid & r_awready;
  assign w_w_hs   = s_axi_wvalid & r_wready;
  assign w_ar_hs  = s_axi_arvalid & r_arready;

  // Held halves stay set through the response, so commit is gated on !bvalid.
  assign w_commit = !r_bvalid && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
  assign w_widx   = r_aw_held ? r_aw_idx : s_axi_awaddr[ADDR_WIDTH-1:ADDR_LSB];
  assign w_wdata  = r_w_held ? r_w_data : s_axi_wdata;
  assign w_ridx   = s_axi_araddr[ADDR_WIDTH-1:ADDR_LSB];
  assign w_w_in_range = 32'(w_widx) < NUM_REGS;
  assign w_r_in_range = 32'(w_ridx) < NUM_REGS;

`ifdef AXI_REGFILE_WSTRB_EN
  logic [DATA_WIDTH/8-1:0] r_w_strb;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic [DATA_WIDTH-1:0]   w_wmask;

  assign w_strb = r_w_held ? r_w_strb : s_axi_wstrb;
  for (genvar gi = 0; gi < DATA_WIDTH/8; gi++) begin : g_mask
    assign w_wmask[gi*8 +: 8] = {8{w_strb[gi]}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_w_strb <= '0;
    else if (w_w_hs) r_w_strb <= s_axi_wstrb;
  end

  assign w_unused_bits = ^{s_axi_awaddr[ADDR_LSB-1:0], s_axi_araddr[ADDR_LSB-1:0]};
`else
  assign w_unused_bits = ^{s_axi_awaddr[ADDR_LSB-1:0], s_axi_araddr[ADDR_LSB-1:0], s_axi_wstrb};
`endif

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic [DATA_WIDTH-1:0] r_q;
    logic [DATA_WIDTH-1:0] w_next;

    assign w_we[gi] = w_commit && w_w_in_range && (32'(w_widx) == gi);
`ifdef AXI_REGFILE_WSTRB_EN
    assign w_next = (r_q & ~w_wmask) | (w_wdata & w_wmask);
`else
    assign w_next = w_wdata;
`endif

    always_ff @(posedge clk or posedge rst) begin
      if (rst)           r_q <= '0;
      else if (w_we[gi]) r_q <= w_next;
    end

    assign w_regs_flat[gi*DATA_WIDTH +: DATA_WIDTH] = r_q;
  end

  // Out-of-range indices match no register and therefore read as zero.
  always_comb begin
    w_rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (32'(w_ridx) == i) w_rd_word = w_regs_flat[i*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_aw_idx   <= '0;
      r_w_data   <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_wr_pulse <= '0;
    end else begin
      // Ready recovers one cycle after the B handshake, giving a 3-cycle write period.
      r_awready  <= !w_aw_hs && !r_aw_held && !r_bvalid;
      r_wready   <= !w_w_hs && !r_w_held && !r_bvalid;
      r_wr_pulse <= w_we;
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_aw_idx  <= s_axi_awaddr[ADDR_WIDTH-1:ADDR_LSB];
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_w_data <= s_axi_wdata;
      end
      if (w_commit) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_w_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if (r_bvalid && s_axi_bready) begin
        r_bvalid  <= 1'b0;
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else begin
      r_arready <= !(w_ar_hs || (r_rvalid && !s_axi_rready));
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_word;
        r_rresp  <= w_r_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if (r_rvalid && s_axi_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign s_axi_awready = r_awready;
  assign s_axi_wready  = r_wready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;
  assign regs_o        = w_regs_flat;
  assign wr_pulse_o    = r_wr_pulse;

endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// Directed bench for axi_lite_regfile_slave: handshake ordering, strobes, SLVERR, backpressure, reset.
module tb_axi_lite_regfile_slave;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int NR = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   awaddr, araddr;
  logic            awvalid, awready, wvalid, wready, bvalid, bready;
  logic            arvalid, arready, rvalid, rready;
  logic [DW-1:0]   wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic [1:0]      bresp, rresp;
  logic [NR*DW-1:0] regs;
  logic [NR-1:0]   wr_pulse;
  logic [NR*DW-1:0] exp_regs;

  int total = 0;
  int bad   = 0;

  axi_lite_regfile_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .regs_o(regs), .wr_pulse_o(wr_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Simultaneous AW+W; returns on the negedge after the handshake edge.
  task automatic aw_w(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] s);
    int n;
    n = 0;
    while (!(awready && wready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wr_ready_wait", 256'(awready && wready), 256'(1));
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b1; araddr = '0; arvalid = 1'b0; rready = 1'b1;
    exp_regs = '0;

    @(negedge clk);
    chk("rst_regs", 256'(regs), 256'(0));
    chk("rst_bvalid", 256'(bvalid), 256'(0));
    chk("rst_rvalid", 256'(rvalid), 256'(0));
    chk("rst_pulse", 256'(wr_pulse), 256'(0));
    chk("rst_readies", 256'({awready, wready, arready}), 256'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_readies", 256'({awready, wready, arready}), 256'(3'b111));

    // simultaneous AW+W to reg0
    aw_w(6'h00, 32'hDEADBEEF, 4'hF);
    exp_regs[31:0] = 32'hDEADBEEF;
    $display("txn write addr=0x00 data=deadbeef");
    chk("t1_bvalid", 256'(bvalid), 256'(1));
    chk("t1_bresp", 256'(bresp), 256'(0));
    chk("t1_regs", 256'(regs), 256'(exp_regs));
    chk("t1_pulse", 256'(wr_pulse), 256'(8'h01));
    chk("t1_awready_low", 256'(awready), 256'(0));
    @(negedge clk);
    chk("t1_bvalid_clr", 256'(bvalid), 256'(0));
    chk("t1_pulse_clr", 256'(wr_pulse), 256'(0));
    chk("t1_recovery", 256'(awready), 256'(0));
    @(negedge clk);
    chk("t1_ready_back", 256'({awready, wready}), 256'(2'b11));

    // W three cycles ahead of AW
    wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    chk("t2_wready_low", 256'(wready), 256'(0));
    chk("t2_awready_high", 256'(awready), 256'(1));
    chk("t2_no_bvalid", 256'(bvalid), 256'(0));
    repeat (2) @(negedge clk);
    chk("t2_still_no_bvalid", 256'(bvalid), 256'(0));
    chk("t2_regs_unchanged", 256'(regs), 256'(exp_regs));
    awaddr = 6'h04; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    exp_regs[63:32] = 32'h12345678;
    $display("txn write addr=0x04 data=12345678 (W first)");
    chk("t2_bvalid", 256'(bvalid), 256'(1));
    chk("t2_bresp", 256'(bresp), 256'(0));
    chk("t2_regs", 256'(regs), 256'(exp_regs));
    chk("t2_pulse", 256'(wr_pulse), 256'(8'h02));
    @(negedge clk);
    araddr = 6'h04; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    $display("txn read addr=0x04");
    chk("t2_rvalid", 256'(rvalid), 256'(1));
    chk("t2_rdata", 256'(rdata), 256'(32'h12345678));
    chk("t2_rresp", 256'(rresp), 256'(0));
    chk("t2_arready_low", 256'(arready), 256'(0));
    @(negedge clk);
    chk("t2_rvalid_clr", 256'(rvalid), 256'(0));
    chk("t2_arready_back", 256'(arready), 256'(1));

    // partial strobe
    aw_w(6'h00, 32'hAAAA5555, 4'h3);
`ifdef AXI_REGFILE_WSTRB_EN
    exp_regs[31:0] = 32'hDEAD5555;
`else
    exp_regs[31:0] = 32'hAAAA5555;
`endif
    $display("txn write addr=0x00 data=aaaa5555 wstrb=3");
    chk("t3_regs", 256'(regs), 256'(exp_regs));
    chk("t3_bresp", 256'(bresp), 256'(0));
    chk("t3_pulse", 256'(wr_pulse), 256'(8'h01));
    @(negedge clk);

    // out-of-range write and read
    aw_w(6'h20, 32'hCAFEF00D, 4'hF);
    $display("txn write addr=0x20 (out of range)");
    chk("t4_bvalid", 256'(bvalid), 256'(1));
    chk("t4_bresp", 256'(bresp), 256'(2'b10));
    chk("t4_pulse", 256'(wr_pulse), 256'(0));
    chk("t4_regs", 256'(regs), 256'(exp_regs));
    @(negedge clk);
    araddr = 6'h3C; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    $display("txn read addr=0x3C (out of range)");
    chk("t4_rvalid", 256'(rvalid), 256'(1));
    chk("t4_rresp", 256'(rresp), 256'(2'b10));
    chk("t4_rdata", 256'(rdata), 256'(0));
    @(negedge clk);

    // B backpressure with a second write pending
    bready = 1'b0;
    aw_w(6'h08, 32'h0BADF00D, 4'hF);
    exp_regs[95:64] = 32'h0BADF00D;
    $display("txn write addr=0x08 data=0badf00d bready=0");
    chk("t5_pulse", 256'(wr_pulse), 256'(8'h04));
    chk("t5_regs", 256'(regs), 256'(exp_regs));
    awaddr = 6'h0C; wdata = 32'h11111111; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t5_bvalid_hold", 256'(bvalid), 256'(1));
      chk("t5_readies_low", 256'({awready, wready}), 256'(0));
      chk("t5_no_second", 256'(regs), 256'(exp_regs));
    end
    bready = 1'b1;
    @(negedge clk);
    chk("t5_bvalid_clr", 256'(bvalid), 256'(0));
    chk("t5_recovery", 256'(awready), 256'(0));
    @(negedge clk);
    chk("t5_ready_back", 256'({awready, wready}), 256'(2'b11));
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    exp_regs[127:96] = 32'h11111111;
    $display("txn write addr=0x0C data=11111111 (after backpressure)");
    chk("t5_second_bvalid", 256'(bvalid), 256'(1));
    chk("t5_second_regs", 256'(regs), 256'(exp_regs));
    chk("t5_second_pulse", 256'(wr_pulse), 256'(8'h08));
    @(negedge clk);

    // R backpressure
    rready = 1'b0;
    araddr = 6'h08; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    $display("txn read addr=0x08 rready=0");
    for (int k = 0; k < 5; k++) begin
      chk("t5_rvalid_hold", 256'(rvalid), 256'(1));
      chk("t5_rdata_hold", 256'(rdata), 256'(32'h0BADF00D));
      chk("t5_arready_low", 256'(arready), 256'(0));
      @(negedge clk);
    end
    rready = 1'b1;
    @(negedge clk);
    chk("t5_rvalid_clr", 256'(rvalid), 256'(0));
    chk("t5_arready_back", 256'(arready), 256'(1));

    // reset while AW is held
    awaddr = 6'h08; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    chk("t6_aw_held", 256'(awready), 256'(0));
    rst = 1'b1;
    #1;
    $display("txn reset with AW held");
    chk("t6_rst_regs", 256'(regs), 256'(0));
    chk("t6_rst_valids", 256'({bvalid, rvalid}), 256'(0));
    chk("t6_rst_pulse", 256'(wr_pulse), 256'(0));
    chk("t6_rst_readies", 256'({awready, wready, arready}), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    exp_regs = '0;
    @(negedge clk);
    chk("t6_ready_after_rst", 256'({awready, wready, arready}), 256'(3'b111));
    wdata = 32'h00000055; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    $display("txn lone W data=55 after reset");
    chk("t6_wready_low", 256'(wready), 256'(0));
    chk("t6_no_bvalid", 256'(bvalid), 256'(0));
    repeat (3) @(negedge clk);
    chk("t6_still_no_bvalid", 256'(bvalid), 256'(0));
    chk("t6_no_pulse", 256'(wr_pulse), 256'(0));
    chk("t6_regs_zero", 256'(regs), 256'(exp_regs));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
